// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory store path.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
// Contents: IO_ADDR_DEFAULT, store_entry_t (word address, data, byte enables), is_io().
package dmem_pkg;

  // Default byte address of the memory-mapped output register.
  localparam logic [31:0] IO_ADDR_DEFAULT = 32'd256;

  // One buffered RAM store. The word address drops the two byte-offset bits.
  typedef struct packed {
    logic [29:0] wa;
    logic [31:0] wd;
    logic [3:0]  be;
  } store_entry_t;

  // Word-granular compare against the IO register address.
  function automatic logic is_io(input logic [29:0] wa, input logic [29:0] io_wa);
    return wa == io_wa;
  endfunction

endpackage

// File: rtl/dmem_store_unit_if.sv
// Bundle of core-side store, RAM write-port, load-hazard and IO signals.
// Latency: n/a (wiring only).
// Backpressure: cpu_ready towards the core, mem_busy from the RAM port.
// Modports: master = core/fabric side, slave = dmem_store_unit.
interface dmem_store_unit_if;
  logic        cpu_we;
  logic [31:0] cpu_a;
  logic [31:0] cpu_wd;
  logic [3:0]  cpu_be;
  logic        cpu_ready;
  logic        mem_busy;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [3:0]  mem_be;
  logic [31:0] rd_a;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        fwd_stall;
  logic [31:0] io_out;
  logic        ovf;

  modport master (
    output cpu_we, cpu_a, cpu_wd, cpu_be, mem_busy, rd_a,
    input  cpu_ready, mem_we, mem_a, mem_wd, mem_be,
           fwd_hit, fwd_data, fwd_stall, io_out, ovf
  );

  modport slave (
    input  cpu_we, cpu_a, cpu_wd, cpu_be, mem_busy, rd_a,
    output cpu_ready, mem_we, mem_a, mem_wd, mem_be,
           fwd_hit, fwd_data, fwd_stall, io_out, ovf
  );
endinterface

// File: rtl/dmem_store_unit_fifo.sv
// In-order store FIFO with an age-ordered view of all entries for hazard search.
// Latency: an entry pushed at edge N is visible at head/age view from cycle N+1.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk, reset, push/din, pop, full, empty, head (0 when empty),
//        age_entry/age_valid (index 0 = oldest, DEPTH-1 = newest slot).
module store_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  store_entry_t din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output store_entry_t head,
  output store_entry_t age_entry [DEPTH],
  output logic         age_valid [DEPTH]
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  store_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset: only slots covered by cnt are ever exposed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Rotate storage so index i is the i-th oldest entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_entry[i] = mem[rd_ptr + PW'(i)];
      age_valid[i] = (CW'(i) < cnt);
    end
  end
endmodule

// File: rtl/dmem_store_unit.sv
// Store unit: buffers core RAM stores, drains them to the RAM port, captures IO stores.
// Latency: RAM store accepted at edge N is offered on the RAM port from cycle N+1; IO store updates io_out at the next edge.
// Backpressure: cpu_ready = !full (registered state only); RAM stores while full are dropped and set sticky ovf; drain stalls on mem_busy.
// Ports: clk, reset (sync, active high), bus (dmem_store_unit_if.slave).
// Build option: define DMEM_FWD_EN to forward full-word matches instead of stalling on every match.
module dmem_store_unit
  import dmem_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] IO_ADDR = IO_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  dmem_store_unit_if.slave   bus
);
  logic         cpu_io;
  logic         ram_st;
  logic         rd_io;
  logic         full;
  logic         empty;
  logic         pop;
  store_entry_t din;
  store_entry_t head;
  store_entry_t age_e [DEPTH];
  logic         age_v [DEPTH];
  logic [31:0]  io_q;
  logic         ovf_q;
  logic         unused_addr_bits;

  assign cpu_io = is_io(bus.cpu_a[31:2], IO_ADDR[31:2]);
  assign rd_io  = is_io(bus.rd_a[31:2], IO_ADDR[31:2]);
  assign ram_st = bus.cpu_we && !cpu_io;
  assign pop    = !empty && !bus.mem_busy;
  assign din    = '{wa: bus.cpu_a[31:2], wd: bus.cpu_wd, be: bus.cpu_be};

  assign unused_addr_bits = ^{bus.cpu_a[1:0], bus.rd_a[1:0]};

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ram_st),
    .din       (din),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .age_entry (age_e),
    .age_valid (age_v)
  );

  // IO stores bypass the FIFO entirely, so they are never blocked by cpu_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (bus.cpu_we && cpu_io) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.cpu_be[b]) io_q[8*b +: 8] <= bus.cpu_wd[8*b +: 8];
        end
      end
      // A same-cycle pop does not free room for the push, hence full alone decides.
      if (ram_st && full) ovf_q <= 1'b1;
    end
  end

  assign bus.cpu_ready = !full;
  assign bus.mem_we    = pop;
  assign bus.mem_a     = {head.wa, 2'b00};
  assign bus.mem_wd    = head.wd;
  assign bus.mem_be    = head.be;
  assign bus.io_out    = io_q;
  assign bus.ovf       = ovf_q;

`ifdef DMEM_FWD_EN
  logic        m_found;
  logic [31:0] m_wd;
  logic [3:0]  m_be;

  // Ascending age order: the last match written is the newest one.
  always_comb begin
    m_found = 1'b0;
    m_wd    = '0;
    m_be    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_v[i] && (age_e[i].wa == bus.rd_a[31:2])) begin
        m_found = 1'b1;
        m_wd    = age_e[i].wd;
        m_be    = age_e[i].be;
      end
    end
  end

  assign bus.fwd_hit   = m_found && !rd_io && (m_be == 4'hF);
  assign bus.fwd_data  = bus.fwd_hit ? m_wd : '0;
  assign bus.fwd_stall = m_found && !rd_io && (m_be != 4'hF);
`else
  logic any_match;
  logic unused_fwd_bits;

  always_comb begin
    any_match       = 1'b0;
    unused_fwd_bits = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_v[i] && (age_e[i].wa == bus.rd_a[31:2])) any_match = 1'b1;
      unused_fwd_bits = unused_fwd_bits ^ (^{age_e[i].wd, age_e[i].be});
    end
  end

  assign bus.fwd_hit   = 1'b0;
  assign bus.fwd_data  = '0;
  assign bus.fwd_stall = any_match && !rd_io;
`endif
endmodule

// File: tb/tb_dmem_store_unit.sv
// Self-checking bench for dmem_store_unit: vector table plus RAM-write scoreboard.
// Latency: n/a.
// Backpressure: mem_busy driven per vector.
module tb_dmem_store_unit;
  import dmem_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] IO_A  = 32'd256;
`ifdef DMEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_store_unit_if bus();

  dmem_store_unit #(.DEPTH(DEPTH), .IO_ADDR(IO_A)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          busy;
    logic [31:0] rd;
    bit          chk;
    bit          hit;
    logic [31:0] fdata;
    bit          stall;
  } vec_t;

  wr_t         sb_q[$];
  vec_t        tbl[$];
  bit          pend_push;
  logic [31:0] io_m;
  bit          ovf_m;
  int          n_vec;
  int          n_err;
  int          mon_cnt;
  bit          mon_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, input bit busy, input logic [31:0] rd,
                              input bit c, input bit hit, input logic [31:0] fdata, input bit stall);
    vec_t v;
    v.we = we; v.a = a; v.wd = wd; v.be = be; v.busy = busy; v.rd = rd;
    v.chk = c; v.hit = hit; v.fdata = fdata; v.stall = stall;
    return v;
  endfunction

  // RAM-port monitor: mid-cycle, compares head/strobe with the scoreboard and
  // retires the front entry when a write is expected at the coming edge.
  always @(negedge clk) begin
    if (!reset) begin
      mon_cnt = sb_q.size() - (pend_push ? 1 : 0);
      mon_we  = (mon_cnt > 0) && !bus.mem_busy;
      chk("mem_we", 32'(bus.mem_we), 32'(mon_we));
      if (mon_cnt == 0) begin
        chk("mem_a_empty", bus.mem_a, 32'h0);
        chk("mem_wd_empty", bus.mem_wd, 32'h0);
      end else begin
        chk("mem_a", bus.mem_a, sb_q[0].a);
        chk("mem_wd", bus.mem_wd, sb_q[0].wd);
        chk("mem_be", 32'(bus.mem_be), 32'(sb_q[0].be));
        if (mon_we) void'(sb_q.pop_front());
      end
    end
  end

  task automatic step(input vec_t v);
    @(posedge clk); #1;
    chk("cpu_ready", 32'(bus.cpu_ready), 32'(sb_q.size() < DEPTH));
    chk("ovf", 32'(bus.ovf), 32'(ovf_m));
    chk("io_out", bus.io_out, io_m);
    bus.cpu_we   = v.we;
    bus.cpu_a    = v.a;
    bus.cpu_wd   = v.wd;
    bus.cpu_be   = v.be;
    bus.mem_busy = v.busy;
    bus.rd_a     = v.rd;
    pend_push    = 1'b0;
    if (v.we) begin
      if (v.a[31:2] == IO_A[31:2]) begin
        for (int b = 0; b < 4; b++) if (v.be[b]) io_m[8*b +: 8] = v.wd[8*b +: 8];
      end else if (sb_q.size() < DEPTH) begin
        sb_q.push_back('{a: {v.a[31:2], 2'b00}, wd: v.wd, be: v.be});
        pend_push = 1'b1;
      end else begin
        ovf_m = 1'b1;
      end
    end
    if (v.chk) begin
      #2;
      chk("fwd_hit", 32'(bus.fwd_hit), 32'(v.hit));
      chk("fwd_data", bus.fwd_data, v.fdata);
      chk("fwd_stall", 32'(bus.fwd_stall), 32'(v.stall));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset        = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_a    = '0;
    bus.cpu_wd   = '0;
    bus.cpu_be   = '0;
    bus.mem_busy = 1'b0;
    bus.rd_a     = '0;
    sb_q.delete();
    pend_push = 1'b0;
    ovf_m     = 1'b0;
    io_m      = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'h1);
    chk("rst_io_out", bus.io_out, 32'h0);
    chk("rst_ovf", 32'(bus.ovf), 32'h0);
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_fwd_stall", 32'(bus.fwd_stall), 32'h0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; pend_push = 1'b0; ovf_m = 1'b0; io_m = '0;
    bus.cpu_we = 1'b0; bus.cpu_a = '0; bus.cpu_wd = '0; bus.cpu_be = '0;
    bus.mem_busy = 1'b0; bus.rd_a = '0;

    // Single store, drain next cycle, then empty.
    tbl.push_back(mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Fill while busy, fifth store dropped, store at full with a pop is still refused.
    tbl.push_back(mk(1, 32'h00, 32'hA0A0A0A0, 4'hF, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h04, 32'hA1A1A1A1, 4'hF, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h08, 32'hA2A2A2A2, 4'hF, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h0C, 32'hA3A3A3A3, 4'hF, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h14, 32'hA4A4A4A4, 4'hF, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h18, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // IO register byte-lane updates.
    tbl.push_back(mk(1, 32'h100, 32'h000000AB, 4'b0001, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h100, 32'h12340000, 4'b1100, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Two full-word stores to one address: newest wins when forwarding.
    tbl.push_back(mk(1, 32'h20, 32'h11111111, 4'hF, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h20, 32'h22222222, 4'hF, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h20, 1, FWD, FWD ? 32'h22222222 : 32'h0, !FWD));
    tbl.push_back(mk(1, 32'h24, 32'h33333333, 4'hF, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Partial-mask store: same-cycle push invisible, then stall, other word and IO load clear.
    tbl.push_back(mk(1, 32'h30, 32'h00005555, 4'b0011, 1, 32'h30, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h30, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h34, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100, 1, 0, 0, 0));
    // Zero byte-enable store still drains.
    tbl.push_back(mk(1, 32'h40, 32'h00000099, 4'h0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Reset with entries pending and the RAM port free.
    step(mk(1, 32'h50, 32'hB0B0B0B0, 4'hF, 1, 0, 0, 0, 0, 0));
    step(mk(1, 32'h54, 32'hB1B1B1B1, 4'hF, 1, 0, 0, 0, 0, 0));
    step(mk(1, 32'h58, 32'hB2B2B2B2, 4'hF, 1, 0, 0, 0, 0, 0));
    step(mk(1, 32'h14, 32'hB3B3B3B3, 4'hF, 1, 0, 0, 0, 0, 0));
    step(mk(1, 32'h18, 32'hB4B4B4B4, 4'hF, 1, 0, 0, 0, 0, 0));
    do_reset();

    // Unit still works after the flush.
    step(mk(1, 32'h60, 32'hC0FFEE00, 4'hF, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); #1;
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
